// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, write-channel FSM states
// and the byte-lane merge used when committing strobed writes.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       strb
  );
    return strb ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register file: NUM_REGS x DATA_W words with byte strobes,
// read-only slots sourced from reg_in, per-register write pulses and SLVERR.
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [DATA_W/8-1:0]        s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_W-1:0]          s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int NB = DATA_W / 8;
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

  wr_state_e state, state_nxt;

  logic                ready_en;
  logic                aw_held;
  logic                w_held;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   wdata_q;
  logic [NB-1:0]       wstrb_q;
  logic [1:0]          bresp_q;
  logic [NUM_REGS-1:0] pulse_q;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;

  logic aw_hs, w_hs, ar_hs, commit;
  logic wr_in_range, wr_ro, wr_ok;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_in_range;
  logic [DATA_W-1:0] rd_val;

  // Sub-word address bits carry no meaning for word-wide registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_bvalid  = (state == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_awready = ready_en && !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = ready_en && !w_held && !s_axi_bvalid;
  assign s_axi_arready = ready_en && !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign reg_wr_pulse  = pulse_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign commit = aw_held && w_held;

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= W_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_IDLE: begin
        if (aw_hs)     state_nxt = W_ADDR;
        else if (w_hs) state_nxt = W_DATA;
      end
      W_ADDR, W_DATA: if (commit) state_nxt = W_RESP;
      W_RESP:         if (s_axi_bready) state_nxt = W_IDLE;
      default:        state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) wr_idx <= s_axi_awaddr[ADDR_W-1:2];
    if (w_hs) begin
      wdata_q <= s_axi_wdata;
      wstrb_q <= s_axi_wstrb;
    end
  end

  always_comb begin
    wr_in_range = ({1'b0, wr_idx} < NUM_REGS_L);
    wr_ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_ro = RO_MASK[i];
    end
    wr_ok = wr_in_range && !wr_ro;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
    end else if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < NB; b++) begin
            regs[i][b*8 +: 8] <= byte_merge(regs[i][b*8 +: 8], wdata_q[b*8 +: 8], wstrb_q[b]);
          end
        end
      end
    end
  end

  // Pulse lasts exactly the cycle after commit; bresp holds until the next commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp_q <= AXI_RESP_OKAY;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (commit) begin
        bresp_q <= wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) pulse_q[i] <= wr_ok && (wr_idx == IDX_W'(i));
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs[g];
  end

  assign rd_idx = s_axi_araddr[ADDR_W-1:2];

  always_comb begin
    rd_in_range = ({1'b0, rd_idx} < NUM_REGS_L);
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = RO_MASK[i] ? reg_in[i*DATA_W +: DATA_W] : regs[i];
    end
  end

  // Read data is captured from the pre-commit register value on a colliding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXI_RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in_range ? rd_val : '0;
      rresp_q  <= rd_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Directed bench for axi_lite_reg_bank: 16 x 32-bit registers, register 2 read-only.
module tb_axi_lite_reg_bank;

  localparam int DATA_W = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W = 8;
  localparam logic [NUM_REGS-1:0] RO_MASK = 16'h0004;

  function automatic logic [NUM_REGS*DATA_W-1:0] mk_reset();
    logic [NUM_REGS*DATA_W-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = 32'h5A00_0000 | i;
    return v;
  endfunction

  localparam logic [NUM_REGS*DATA_W-1:0] RESET_VAL = mk_reset();

  logic clk = 1'b0;
  logic rst_n;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NUM_REGS*DATA_W-1:0] reg_out, reg_in;
  logic [NUM_REGS-1:0] reg_wr_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cycles = 0;
  logic [31:0] exp_regs [NUM_REGS];

  always #5 clk = ~clk;

  axi_lite_reg_bank #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
    .RO_MASK(RO_MASK), .RESET_VAL(RESET_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .reg_in(reg_in), .reg_wr_pulse(reg_wr_pulse)
  );

  always @(negedge clk) if (|reg_wr_pulse) pulse_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int i);
    return reg_out[i*DATA_W +: DATA_W];
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input logic [15:0] exp_pulse, input string tag);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    check({tag, " awready"}, 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, " bvalid_early"}, 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    check({tag, " bvalid"}, 32'(bvalid), 32'd1);
    check({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
    check({tag, " pulse"}, 32'(reg_wr_pulse), 32'(exp_pulse));
    @(posedge clk); #1;
    check({tag, " bvalid_clr"}, 32'(bvalid), 32'd0);
    check({tag, " pulse_clr"}, 32'(reg_wr_pulse), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check({tag, " rvalid"}, 32'(rvalid), 32'd1);
    check({tag, " rdata"}, rdata, exp_data);
    check({tag, " rresp"}, 32'(rresp), 32'(exp_resp));
    @(posedge clk); #1;
    check({tag, " rvalid_clr"}, 32'(rvalid), 32'd0);
  endtask

  initial begin
    int pc;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    reg_in = '0;
    reg_in[2*DATA_W +: DATA_W] = 32'h0000_CAFE;
    for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 32'h5A00_0000 | i;
    exp_regs[2] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst awready", 32'(awready), 32'd0);
    check("rst arready", 32'(arready), 32'd0);
    check("rst bvalid", 32'(bvalid), 32'd0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst rdata", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst awready", 32'(awready), 32'd1);
    check("post_rst wready", 32'(wready), 32'd1);
    check("post_rst arready", 32'(arready), 32'd1);

    for (int i = 0; i < NUM_REGS; i++) begin
      if (i != 2) do_read(8'(i * 4), 32'h5A00_0000 | i, 2'b00, $sformatf("rst_rd%0d", i));
    end
    check("rst pulse_cycles", 32'(pulse_cycles), 32'd0);
    check("ro slot2 out", slot(2), 32'd0);

    do_write(8'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 16'h0002, "wr1");
    exp_regs[1] = 32'hDEAD_BEEF;
    check("wr1 reg_out", slot(1), 32'hDEAD_BEEF);
    check("wr1 pulse_cycles", 32'(pulse_cycles), 32'd1);
    do_read(8'h04, 32'hDEAD_BEEF, 2'b00, "rd1");
    do_read(8'h07, 32'hDEAD_BEEF, 2'b00, "rd1_lowbits");

    do_write(8'h14, 32'hAAAA_AAAA, 4'hF, 2'b00, 16'h0020, "wr5_full");
    pc = pulse_cycles;
    wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("wfirst wready_held", 32'(wready), 32'd0);
    check("wfirst awready", 32'(awready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("wfirst no_commit", 32'(bvalid), 32'd0);
    awaddr = 8'h14; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("wfirst bvalid_early", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    check("wfirst pulse", 32'(reg_wr_pulse), 32'h0020);
    check("wfirst reg_out", slot(5), 32'hAA22_AA44);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bhold%0d bvalid", k), 32'(bvalid), 32'd1);
      check($sformatf("bhold%0d bresp", k), 32'(bresp), 32'd0);
      @(posedge clk); #1;
    end
    check("bhold awready", 32'(awready), 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    check("bhold bvalid_clr", 32'(bvalid), 32'd0);
    check("wfirst pulse_cycles", 32'(pulse_cycles - pc), 32'd1);
    exp_regs[5] = 32'hAA22_AA44;
    do_read(8'h14, 32'hAA22_AA44, 2'b00, "rd5");

    pc = pulse_cycles;
    do_write(8'h08, 32'h1234_5678, 4'hF, 2'b10, 16'h0000, "wr_ro");
    check("wr_ro pulse_cycles", 32'(pulse_cycles - pc), 32'd0);
    check("wr_ro reg_out", slot(2), 32'd0);
    do_read(8'h08, 32'h0000_CAFE, 2'b00, "rd_ro");

    do_write(8'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 16'h0000, "wr_oor");
    for (int i = 0; i < NUM_REGS; i++) check($sformatf("oor slot%0d", i), slot(i), exp_regs[i]);
    do_read(8'h40, 32'd0, 2'b10, "rd_oor");

    awaddr = 8'h0C; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h0C; arvalid = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("coll rvalid", 32'(rvalid), 32'd1);
    check("coll rdata_old", rdata, 32'h5A00_0003);
    check("coll bvalid", 32'(bvalid), 32'd1);
    check("coll pulse", 32'(reg_wr_pulse), 32'h0008);
    @(posedge clk); #1;
    check("coll rvalid_clr", 32'(rvalid), 32'd0);
    do_read(8'h0C, 32'h0BAD_F00D, 2'b00, "coll_rd_new");

    wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 8'h04; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0; arvalid = 1'b0;
    check("mid wready_held", 32'(wready), 32'd0);
    check("mid rvalid_pend", 32'(rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst rvalid", 32'(rvalid), 32'd0);
    check("mid_rst bvalid", 32'(bvalid), 32'd0);
    check("mid_rst rdata", rdata, 32'd0);
    check("mid_rst pulse", 32'(reg_wr_pulse), 32'd0);
    check("mid_rst awready", 32'(awready), 32'd0);
    check("mid_rst slot1", slot(1), 32'h5A00_0001);
    check("mid_rst slot3", slot(3), 32'h5A00_0003);
    check("mid_rst slot5", slot(5), 32'h5A00_0005);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel wready", 32'(wready), 32'd1);
    check("mid_rel arready", 32'(arready), 32'd1);
    pc = pulse_cycles;
    awaddr = 8'h18; awvalid = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("aw_only bvalid", 32'(bvalid), 32'd0);
    check("aw_only pulses", 32'(pulse_cycles - pc), 32'd0);
    check("aw_only slot6", slot(6), 32'h5A00_0006);
    wdata = 32'h0000_0066; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(posedge clk); #1;
    check("late_w bvalid", 32'(bvalid), 32'd1);
    check("late_w bresp", 32'(bresp), 32'd0);
    check("late_w pulse", 32'(reg_wr_pulse), 32'h0040);
    check("late_w slot6", slot(6), 32'h0000_0066);
    @(posedge clk); #1;
    check("late_w bvalid_clr", 32'(bvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
